// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern-detector sequencer.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CNT_W   = 5;
  localparam int DEF_DET_LAT = 1;

endpackage

// File: rtl/seq_det_piso.sv
// Loadable LSB-first parallel-in/serial-out shift register.
// head is always the next bit to be sent; pre_shift drops bit 0 at load time.
module seq_det_piso #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             pre_shift,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             head
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      // pre_shift is used when bit 0 leaves on the load edge itself
      sr <= pre_shift ? (data_in >> 1) : data_in;
    end else if (shift) begin
      sr <= sr >> 1;
    end
  end

  assign head = sr[0];

endmodule

// File: rtl/seq_det_scan_ctrl.sv
// Feeds parallel words bit-serially into a pattern detector and collects
// per-bit detection results (count and position mask) for each word.
module seq_det_scan_ctrl
  import seq_det_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DET_LAT = DEF_DET_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fresh,
  output logic             serial_out,
  output logic             det_reset_n,
  input  logic             detect_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [WIDTH-1:0] hit_mask
);

  localparam int CYC_W      = $clog2(WIDTH + DET_LAT + 1);
  localparam int LAST_SHIFT = WIDTH - 1;
  localparam int LAST_CYC   = WIDTH + DET_LAT - 1;

  state_t           state, state_next;
  logic [CYC_W-1:0] cyc, cyc_next;
  logic             serial_next;
  logic             accept;
  logic             sampling;
  logic             piso_head;
  logic [WIDTH-1:0] hit_vec;

  assign start_ready = (state == IDLE) || (state == DONE);
  assign busy        = ~start_ready;
  assign done        = (state == DONE);
  assign accept      = start_valid & start_ready;
  assign sampling    = (state == SHIFT) || (state == DRAIN);

  seq_det_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .pre_shift(~fresh),
    .shift    ((state == FLUSH) || (state == SHIFT)),
    .data_in  (data_in),
    .head     (piso_head)
  );

  // Sample taken at the end of cycle c belongs to bit c-DET_LAT.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hit
    assign hit_vec[gi] = sampling & detect_in & (cyc == CYC_W'(gi + DET_LAT));
  end

  always_comb begin
    state_next  = state;
    cyc_next    = cyc;
    serial_next = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next  = fresh ? FLUSH : SHIFT;
          cyc_next    = '0;
          serial_next = fresh ? 1'b0 : data_in[0];
        end else begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        state_next  = SHIFT;
        serial_next = piso_head;
      end
      SHIFT: begin
        cyc_next = cyc + CYC_W'(1);
        if (cyc == CYC_W'(LAST_SHIFT)) begin
          state_next = (DET_LAT == 0) ? DONE : DRAIN;
        end else begin
          serial_next = piso_head;
        end
      end
      DRAIN: begin
        cyc_next = cyc + CYC_W'(1);
        if (cyc == CYC_W'(LAST_CYC)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cyc         <= '0;
      serial_out  <= 1'b0;
      det_reset_n <= 1'b0;
      hit_count   <= '0;
      hit_mask    <= '0;
    end else begin
      state       <= state_next;
      cyc         <= cyc_next;
      serial_out  <= serial_next;
      // the detector is held in reset only for the single flush cycle
      det_reset_n <= (state_next != FLUSH);
      if (accept) begin
        hit_count <= '0;
        hit_mask  <= '0;
      end else if (|hit_vec) begin
        hit_count <= hit_count + CNT_W'(1);
        hit_mask  <= hit_mask | hit_vec;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Directed bench: sequencer driving an overlapping, registered 101 detector.
module tb_seq_det_scan_ctrl;

  logic        clock;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] data_in;
  logic        fresh;
  logic        serial_out;
  logic        det_reset_n;
  logic        detect_in;
  logic        busy;
  logic        done;
  logic [4:0]  hit_count;
  logic [15:0] hit_mask;

  int n_vec  = 0;
  int n_miss = 0;

  seq_det_scan_ctrl #(
    .WIDTH  (16),
    .CNT_W  (5),
    .DET_LAT(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .data_in    (data_in),
    .fresh      (fresh),
    .serial_out (serial_out),
    .det_reset_n(det_reset_n),
    .detect_in  (detect_in),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count),
    .hit_mask   (hit_mask)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Detector advances only on shifted data bits, so its state carries
  // across words unless the sequencer flushes it.
  int         win;
  logic       skip;
  logic       det_en;
  logic [1:0] det_st;
  logic       det_q;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      win  <= 0;
      skip <= 1'b0;
    end else if (start_valid && start_ready) begin
      win  <= 16;
      skip <= fresh;
    end else if (skip) begin
      skip <= 1'b0;
    end else if (win != 0) begin
      win <= win - 1;
    end
  end

  assign det_en = (win != 0) && !skip;

  always @(posedge clock or negedge det_reset_n) begin
    if (!det_reset_n) begin
      det_st <= 2'd0;
      det_q  <= 1'b0;
    end else if (det_en) begin
      det_q <= (det_st == 2'd2) && serial_out;
      case (det_st)
        2'd0:    det_st <= serial_out ? 2'd1 : 2'd0;
        2'd1:    det_st <= serial_out ? 2'd1 : 2'd2;
        default: det_st <= serial_out ? 2'd1 : 2'd0;
      endcase
    end else begin
      det_q <= 1'b0;
    end
  end

  assign detect_in = det_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the controller ready; returns at the
  // falling edge inside the DONE cycle. Cycle 0 is the accept cycle.
  task automatic run_word(input logic [15:0] d, input logic f, input int poke, output int lat);
    int cyc;
    int k;
    check_val("ready", start_ready, 1);
    data_in     = d;
    fresh       = f;
    start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    cyc = 1;
    while (1) begin
      @(negedge clock);
      if (cyc == poke) begin
        check_val("busy_poke", busy, 1);
        start_valid = 1'b1;
        data_in     = 16'hFFFF;
        fresh       = 1'b0;
      end else if (cyc == poke + 1) begin
        start_valid = 1'b0;
      end
      k = cyc - (f ? 2 : 1);
      if (k >= 0 && k < 16) check_val("serial", serial_out, d[k]);
      check_val("det_rst", det_reset_n, (f && cyc == 1) ? 0 : 1);
      if (done || cyc >= 60) break;
      cyc++;
    end
    lat = cyc;
    $display("word %h fresh %0d: latency %0d count %0d mask %h", d, f, lat, hit_count, hit_mask);
  endtask

  int lat;
  int ndone;
  int first_done;

  initial begin
    reset       = 1'b0;
    start_valid = 1'b0;
    data_in     = '0;
    fresh       = 1'b0;

    #2;
    check_val("rst_ready", start_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_serial", serial_out, 0);
    check_val("rst_detrst", det_reset_n, 0);
    check_val("rst_count", hit_count, 0);
    check_val("rst_mask", hit_mask, 0);

    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 check_val("rel_detrst_low", det_reset_n, 0);
    @(negedge clock);
    check_val("rel_detrst_high", det_reset_n, 1);
    check_val("rel_ready", start_ready, 1);

    // flushed word: hits at bits 3, 6, 11
    run_word(16'b0100_1010_0101_1011, 1'b1, 0, lat);
    check_val("w1_lat", lat, 19);
    check_val("w1_count", hit_count, 3);
    check_val("w1_mask", hit_mask, 16'h0848);

    // back-to-back, no flush: trailing "10" plus new bit 0 completes 101
    run_word(16'b0100_1010_0101_1011, 1'b0, 0, lat);
    check_val("w2_lat", lat, 18);
    check_val("w2_count", hit_count, 4);
    check_val("w2_mask", hit_mask, 16'h0849);

    @(negedge clock);
    run_word(16'h0000, 1'b1, 0, lat);
    check_val("zero_lat", lat, 19);
    check_val("zero_count", hit_count, 0);
    check_val("zero_mask", hit_mask, 0);

    run_word(16'hFFFF, 1'b1, 0, lat);
    check_val("ones_count", hit_count, 0);
    check_val("ones_mask", hit_mask, 0);

    run_word(16'h5555, 1'b1, 0, lat);
    check_val("dense_count", hit_count, 7);
    check_val("dense_mask", hit_mask, 16'h5554);

    // start_valid pulse while busy must be ignored
    run_word(16'h5555, 1'b1, 6, lat);
    check_val("poke_lat", lat, 19);
    check_val("poke_count", hit_count, 7);
    check_val("poke_mask", hit_mask, 16'h5554);

    // start_valid held high: one accept per DONE window
    data_in     = 16'h5555;
    fresh       = 1'b1;
    start_valid = 1'b1;
    ndone       = 0;
    first_done  = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        check_val("held_cycle", i, 19 * ndone);
        check_val("held_count", hit_count, 7);
        if (ndone == 1) first_done = i;
      end
    end
    start_valid = 1'b0;
    check_val("held_ndone", ndone, 3);
    check_val("held_first", first_done, 19);

    for (int i = 0; i < 30 && !done; i++) @(negedge clock);
    check_val("held_last_done", done, 1);
    check_val("held_last_count", hit_count, 7);

    // asynchronous reset in the middle of a word
    data_in     = 16'b0100_1010_0101_1011;
    fresh       = 1'b1;
    start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    repeat (11) @(negedge clock);
    check_val("mid_busy", busy, 1);
    check_val("mid_count", hit_count, 2);
    check_val("mid_mask", hit_mask, 16'h0048);
    #2 reset = 1'b0;
    #1;
    check_val("arst_ready", start_ready, 1);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_serial", serial_out, 0);
    check_val("arst_detrst", det_reset_n, 0);
    check_val("arst_count", hit_count, 0);
    check_val("arst_mask", hit_mask, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 check_val("arel_detrst_low", det_reset_n, 0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (i == 0) check_val("arel_detrst_high", det_reset_n, 1);
      if (done) ndone++;
    end
    check_val("arel_no_done", ndone, 0);
    check_val("arel_ready", start_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
